// File: rtl/card_board_mem_pkg.sv
// Shared card-board sizes, state encodings, palette and board-size helper.
package card_board_mem_pkg;

  localparam int unsigned CARD_ADDRESS_SIZE = 5;
  localparam int unsigned CARD_STATE_SIZE   = 2;
  localparam int unsigned CARD_COLOR_SIZE   = 12;
  localparam int unsigned CARD_MAX_NUM_SIZE = 6;
  localparam int unsigned CARD_NUM          = 32;

  localparam logic [CARD_STATE_SIZE-1:0] CARD_EMPTY      = 2'b00;
  localparam logic [CARD_STATE_SIZE-1:0] CARD_COVERED    = 2'b01;
  localparam logic [CARD_STATE_SIZE-1:0] CARD_MATCHED    = 2'b10;
  localparam logic [CARD_STATE_SIZE-1:0] CARD_DISCOVERED = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPick,
    StSwap,
    StDone
  } build_state_e;

  // 16-entry pair palette; entries are distinct and nonzero so 0 means "no card".
  function automatic logic [CARD_COLOR_SIZE-1:0] palette(input logic [3:0] idx);
    logic [CARD_COLOR_SIZE-1:0] c;
    unique case (idx)
      4'd0:    c = 12'hF00;
      4'd1:    c = 12'h0F0;
      4'd2:    c = 12'h00F;
      4'd3:    c = 12'hFF0;
      4'd4:    c = 12'hF0F;
      4'd5:    c = 12'h0FF;
      4'd6:    c = 12'hF80;
      4'd7:    c = 12'h8F0;
      4'd8:    c = 12'h08F;
      4'd9:    c = 12'hF08;
      4'd10:   c = 12'h80F;
      4'd11:   c = 12'h0F8;
      4'd12:   c = 12'h888;
      4'd13:   c = 12'hFFF;
      4'd14:   c = 12'h840;
      default: c = 12'h048;
    endcase
    return c;
  endfunction

  // Even board size clamped to 2..32.
  function automatic logic [CARD_MAX_NUM_SIZE-1:0] board_size(
    input logic [CARD_MAX_NUM_SIZE-1:0] num
  );
    logic [CARD_MAX_NUM_SIZE-1:0] even;
    even = num & 6'h3E;
    if (even < 6'd2) begin
      return 6'd2;
    end else if (even > 6'd32) begin
      return 6'd32;
    end
    return even;
  endfunction

endpackage

// File: rtl/card_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); exposes its low bits.
module card_lfsr16 #(
  parameter logic [15:0] Seed = 16'hACE1,
  parameter int unsigned OutW = 5
) (
  input  logic            clk,
  input  logic            rst,
  output logic [OutW-1:0] rand_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift left, feedback from taps 16,14,13,11 (bits 15,13,12,10).
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // State register, reloads the seed on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rand_o = lfsr_q[OutW-1:0];

endmodule

// File: rtl/card_board_mem.sv
// Card board store: builds/shuffles the board, answers clicks, applies state writes
// and streams the whole board to the renderer on request.
module card_board_mem
  import card_board_mem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CARD_MAX_NUM_SIZE-1:0] num_of_cards,
  input  logic                         start_game_en,
  output logic                         compute_done,
  input  logic                         wait_for_click_en,
  input  logic                         mouse_click,
  input  logic                         hit_valid,
  input  logic [CARD_ADDRESS_SIZE-1:0] hit_address,
  output logic                         card_pressed,
  output logic [CARD_ADDRESS_SIZE-1:0] card_clicked_address,
  output logic [CARD_COLOR_SIZE-1:0]   card_clicked_color,
  input  logic                         write_card_en,
  input  logic [CARD_STATE_SIZE-1:0]   write_card_state,
  input  logic [CARD_ADDRESS_SIZE-1:0] write_card_address,
  input  logic                         update_cards_en,
  output logic                         upd_valid,
  output logic [CARD_ADDRESS_SIZE-1:0] upd_address,
  output logic [CARD_STATE_SIZE-1:0]   upd_state,
  output logic [CARD_COLOR_SIZE-1:0]   upd_color,
  output logic                         upd_done
);

  logic [CARD_STATE_SIZE-1:0]   state_q [CARD_NUM];
  logic [CARD_STATE_SIZE-1:0]   state_d [CARD_NUM];
  logic [CARD_COLOR_SIZE-1:0]   color_q [CARD_NUM];
  logic [CARD_COLOR_SIZE-1:0]   color_d [CARD_NUM];

  build_state_e                 bst_q, bst_d;
  logic [CARD_MAX_NUM_SIZE-1:0] n_q, n_d;
  logic [CARD_ADDRESS_SIZE-1:0] i_q, i_d, j_q, j_d;
  logic                         start_prev_q;
  logic                         start_rise;
  logic [CARD_ADDRESS_SIZE-1:0] rand_idx;

  logic                         pressed_q, pressed_d;
  logic [CARD_ADDRESS_SIZE-1:0] clk_addr_q, clk_addr_d;
  logic [CARD_COLOR_SIZE-1:0]   clk_color_q, clk_color_d;
  logic                         accept;

  logic                         sw_active_q, sw_active_d;
  logic [CARD_ADDRESS_SIZE-1:0] sw_addr_q, sw_addr_d;
  logic                         sw_done_q, sw_done_d;

  card_lfsr16 #(
    .Seed(SEED),
    .OutW(CARD_ADDRESS_SIZE)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .rand_o(rand_idx)
  );

  assign start_rise = start_game_en & ~start_prev_q;

  // Build FSM plus card storage next-state; external writes land only while idle.
  always_comb begin
    bst_d   = bst_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    state_d = state_q;
    color_d = color_q;
    unique case (bst_q)
      StIdle: begin
        if (start_rise) begin
          n_d   = board_size(num_of_cards);
          bst_d = StFill;
        end
        if (write_card_en) begin
          state_d[write_card_address] = write_card_state;
        end
      end
      StFill: begin
        for (int k = 0; k < CARD_NUM; k++) begin
          if (6'(k) < n_q) begin
            state_d[k] = CARD_COVERED;
            color_d[k] = palette(4'(k >> 1));
          end else begin
            state_d[k] = CARD_EMPTY;
            color_d[k] = '0;
          end
        end
        i_d   = 5'(n_q - 6'd1);
        bst_d = StPick;
      end
      StPick: begin
        // Rejection sampling keeps j uniform over 0..i.
        if (rand_idx <= i_q) begin
          j_d   = rand_idx;
          bst_d = StSwap;
        end
      end
      StSwap: begin
        color_d[i_q] = color_q[j_q];
        color_d[j_q] = color_q[i_q];
        if (i_q == 5'd1) begin
          bst_d = StDone;
        end else begin
          i_d   = i_q - 5'd1;
          bst_d = StPick;
        end
      end
      StDone:  bst_d = StIdle;
      default: bst_d = StIdle;
    endcase
  end

  // Click responder: evaluated on the pre-write state, latched for the renderer.
  always_comb begin
    accept      = mouse_click & hit_valid & wait_for_click_en & (bst_q == StIdle) &
                  (state_q[hit_address] == CARD_COVERED);
    pressed_d   = accept;
    clk_addr_d  = clk_addr_q;
    clk_color_d = clk_color_q;
    if (accept) begin
      clk_addr_d  = hit_address;
      clk_color_d = color_q[hit_address];
    end
  end

  // Sweep counter: a new game aborts it, a new pulse restarts it at 0.
  always_comb begin
    sw_active_d = sw_active_q;
    sw_addr_d   = sw_addr_q;
    sw_done_d   = 1'b0;
    if (start_rise) begin
      sw_active_d = 1'b0;
      sw_addr_d   = '0;
    end else if (update_cards_en) begin
      sw_active_d = 1'b1;
      sw_addr_d   = '0;
    end else if (sw_active_q) begin
      if (sw_addr_q == 5'd31) begin
        sw_active_d = 1'b0;
        sw_addr_d   = '0;
        sw_done_d   = 1'b1;
      end else begin
        sw_addr_d = sw_addr_q + 5'd1;
      end
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CARD_NUM; k++) begin
        state_q[k] <= CARD_EMPTY;
        color_q[k] <= '0;
      end
      bst_q        <= StIdle;
      n_q          <= 6'd2;
      i_q          <= '0;
      j_q          <= '0;
      start_prev_q <= 1'b0;
      pressed_q    <= 1'b0;
      clk_addr_q   <= '0;
      clk_color_q  <= '0;
      sw_active_q  <= 1'b0;
      sw_addr_q    <= '0;
      sw_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      color_q      <= color_d;
      bst_q        <= bst_d;
      n_q          <= n_d;
      i_q          <= i_d;
      j_q          <= j_d;
      start_prev_q <= start_game_en;
      pressed_q    <= pressed_d;
      clk_addr_q   <= clk_addr_d;
      clk_color_q  <= clk_color_d;
      sw_active_q  <= sw_active_d;
      sw_addr_q    <= sw_addr_d;
      sw_done_q    <= sw_done_d;
    end
  end

  assign compute_done         = (bst_q == StDone);
  assign card_pressed         = pressed_q;
  assign card_clicked_address = clk_addr_q;
  assign card_clicked_color   = clk_color_q;
  assign upd_valid            = sw_active_q;
  assign upd_address          = sw_active_q ? sw_addr_q : '0;
  assign upd_state            = sw_active_q ? state_q[sw_addr_q] : '0;
  assign upd_color            = sw_active_q ? color_q[sw_addr_q] : '0;
  assign upd_done             = sw_done_q;

endmodule

// File: tb/tb_card_board_mem.sv
// Directed, table-driven bench for card_board_mem.
module tb_card_board_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  num_of_cards;
  logic        start_game_en;
  logic        compute_done;
  logic        wait_for_click_en;
  logic        mouse_click;
  logic        hit_valid;
  logic [4:0]  hit_address;
  logic        card_pressed;
  logic [4:0]  card_clicked_address;
  logic [11:0] card_clicked_color;
  logic        write_card_en;
  logic [1:0]  write_card_state;
  logic [4:0]  write_card_address;
  logic        update_cards_en;
  logic        upd_valid;
  logic [4:0]  upd_address;
  logic [1:0]  upd_state;
  logic [11:0] upd_color;
  logic        upd_done;

  always #5 clk = ~clk;

  card_board_mem #(
    .SEED(16'hACE1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .num_of_cards        (num_of_cards),
    .start_game_en       (start_game_en),
    .compute_done        (compute_done),
    .wait_for_click_en   (wait_for_click_en),
    .mouse_click         (mouse_click),
    .hit_valid           (hit_valid),
    .hit_address         (hit_address),
    .card_pressed        (card_pressed),
    .card_clicked_address(card_clicked_address),
    .card_clicked_color  (card_clicked_color),
    .write_card_en       (write_card_en),
    .write_card_state    (write_card_state),
    .write_card_address  (write_card_address),
    .update_cards_en     (update_cards_en),
    .upd_valid           (upd_valid),
    .upd_address         (upd_address),
    .upd_state           (upd_state),
    .upd_color           (upd_color),
    .upd_done            (upd_done)
  );

  typedef struct {
    logic [5:0] num;
    int         exp_n;
  } vec_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [11:0] pal [16];
  logic [1:0]  sw_state [32];
  logic [11:0] sw_color [32];
  logic [11:0] saved_color [32];
  vec_t        vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input string name);
    int bad = 0;
    @(negedge clk);
    update_cards_en = 1'b1;
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      update_cards_en = 1'b0;
      if (!upd_valid || upd_address != 5'(b) || upd_done) bad++;
      sw_state[b] = upd_state;
      sw_color[b] = upd_color;
    end
    @(negedge clk);
    check({name, "_beats"}, bad, 0);
    check({name, "_done"}, upd_done, 1);
    check({name, "_valid_off"}, upd_valid, 0);
  endtask

  task automatic run_build(input string name, input logic [5:0] num);
    int pulses = 0;
    int waited = 0;
    @(negedge clk);
    num_of_cards  = num;
    start_game_en = 1'b1;
    while (pulses == 0 && waited < 5000) begin
      @(negedge clk);
      waited++;
      if (compute_done) pulses++;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (compute_done) pulses++;
    end
    start_game_en = 1'b0;
    check({name, "_done_pulses"}, pulses, 1);
  endtask

  task automatic check_board(input string name, input int n);
    int bad_state = 0;
    int bad_color = 0;
    int bad_pairs = 0;
    for (int c = 0; c < 32; c++) begin
      if (sw_state[c] != ((c < n) ? 2'b01 : 2'b00)) bad_state++;
      if (c >= n && sw_color[c] != 12'h000) bad_color++;
    end
    for (int p = 0; p < n / 2; p++) begin
      int cnt = 0;
      for (int c = 0; c < n; c++) if (sw_color[c] == pal[p]) cnt++;
      if (cnt != 2) bad_pairs++;
    end
    check({name, "_states"}, bad_state, 0);
    check({name, "_empty_colors"}, bad_color, 0);
    check({name, "_pairs"}, bad_pairs, 0);
  endtask

  // Drive one click (optionally with a same-cycle write); return what the next cycle shows.
  task automatic do_click(input logic [4:0] a, input logic wr, input logic [1:0] ws,
                          output logic pr, output logic [4:0] ad, output logic [11:0] co);
    @(negedge clk);
    mouse_click        = 1'b1;
    hit_valid          = 1'b1;
    hit_address        = a;
    write_card_en      = wr;
    write_card_state   = ws;
    write_card_address = a;
    @(negedge clk);
    mouse_click   = 1'b0;
    hit_valid     = 1'b0;
    write_card_en = 1'b0;
    pr = card_pressed;
    ad = card_clicked_address;
    co = card_clicked_color;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [1:0] ws);
    @(negedge clk);
    write_card_en      = 1'b1;
    write_card_state   = ws;
    write_card_address = a;
    @(negedge clk);
    write_card_en = 1'b0;
  endtask

  initial begin
    logic        pr;
    logic [4:0]  ad;
    logic [11:0] co;
    int          cnt_v;
    int          cnt_d;
    int          bad;

    pal = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF, 12'hF80, 12'h8F0,
            12'h08F, 12'hF08, 12'h80F, 12'h0F8, 12'h888, 12'hFFF, 12'h840, 12'h048};
    vecs[0] = '{num: 6'd8,  exp_n: 8};
    vecs[1] = '{num: 6'd7,  exp_n: 6};
    vecs[2] = '{num: 6'd40, exp_n: 32};
    vecs[3] = '{num: 6'd1,  exp_n: 2};
    vecs[4] = '{num: 6'd33, exp_n: 32};
    vecs[5] = '{num: 6'd12, exp_n: 12};

    rst = 1'b1; num_of_cards = 6'd0; start_game_en = 1'b0; wait_for_click_en = 1'b0;
    mouse_click = 1'b0; hit_valid = 1'b0; hit_address = '0; write_card_en = 1'b0;
    write_card_state = '0; write_card_address = '0; update_cards_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_upd_valid", upd_valid, 0);
    check("rst_upd_done", upd_done, 0);
    check("rst_upd_addr_state_color", {upd_address, upd_state, upd_color}, 0);
    check("rst_card_pressed", card_pressed, 0);
    check("rst_clicked", {card_clicked_address, card_clicked_color}, 0);
    check("rst_compute_done", compute_done, 0);
    run_sweep("rst_sweep");
    bad = 0;
    for (int c = 0; c < 32; c++) if (sw_state[c] != 2'b00 || sw_color[c] != 12'h000) bad++;
    check("rst_sweep_empty", bad, 0);

    // Board builds over the size table.
    for (int v = 0; v < 6; v++) begin
      run_build($sformatf("build%0d", v), vecs[v].num);
      run_sweep($sformatf("sweep%0d", v));
      check_board($sformatf("board%0d", v), vecs[v].exp_n);
    end

    // Fresh 8-card board for the click tests.
    run_build("build8", 6'd8);
    run_sweep("sweep8");
    check_board("board8", 8);
    for (int c = 0; c < 32; c++) saved_color[c] = sw_color[c];

    wait_for_click_en = 1'b1;
    do_click(5'd3, 1'b0, 2'b00, pr, ad, co);
    check("click3_pressed", pr, 1);
    check("click3_addr", ad, 3);
    check("click3_color", co, saved_color[3]);
    @(negedge clk);
    check("click3_pulse_width", card_pressed, 0);

    wait_for_click_en = 1'b0;
    do_click(5'd1, 1'b0, 2'b00, pr, ad, co);
    check("click_disabled", pr, 0);
    check("click_disabled_hold_addr", ad, 3);
    wait_for_click_en = 1'b1;

    do_click(5'd20, 1'b0, 2'b00, pr, ad, co);
    check("click_empty_card", pr, 0);

    do_write(5'd3, 2'b11);
    do_click(5'd3, 1'b0, 2'b00, pr, ad, co);
    check("click_discovered", pr, 0);
    do_write(5'd3, 2'b01);
    do_click(5'd3, 1'b0, 2'b00, pr, ad, co);
    check("click_recovered", pr, 1);

    // Click sees the old state when a write hits the same card in the same cycle.
    do_click(5'd4, 1'b1, 2'b11, pr, ad, co);
    check("click_write_same_cycle", {pr, ad, co}, {1'b1, 5'd4, saved_color[4]});
    do_click(5'd4, 1'b0, 2'b00, pr, ad, co);
    check("click_after_write", pr, 0);

    do_write(5'd2, 2'b10);
    do_write(5'd5, 2'b10);
    run_sweep("sweep_wr");
    check("sweep_wr_states", {sw_state[2], sw_state[3], sw_state[4], sw_state[5]},
          {2'b10, 2'b01, 2'b11, 2'b10});
    check("sweep_wr_colors_kept", sw_color[5], saved_color[5]);

    // New game rise at beat 10 aborts the sweep.
    @(negedge clk);
    update_cards_en = 1'b1;
    for (int b = 0; b <= 10; b++) begin
      @(negedge clk);
      update_cards_en = 1'b0;
    end
    check("abort_beat10_addr", upd_address, 10);
    num_of_cards  = 6'd8;
    start_game_en = 1'b1;
    cnt_v = 0; cnt_d = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (upd_valid) cnt_v++;
      if (upd_done) cnt_d++;
    end
    check("abort_no_valid", cnt_v, 0);
    check("abort_no_done", cnt_d, 0);
    cnt_d = 0;
    for (int c = 0; c < 5000 && !compute_done; c++) @(negedge clk);
    start_game_en = 1'b0;

    // Reset mid-sweep: no done, board cleared.
    @(negedge clk);
    update_cards_en = 1'b1;
    repeat (6) @(negedge clk);
    update_cards_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_v = 0; cnt_d = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (upd_valid) cnt_v++;
      if (upd_done) cnt_d++;
    end
    check("rst_mid_sweep_quiet", {cnt_v[15:0], cnt_d[15:0]}, 0);
    run_sweep("post_rst");
    bad = 0;
    for (int c = 0; c < 32; c++) if (sw_state[c] != 2'b00 || sw_color[c] != 12'h000) bad++;
    check("post_rst_empty", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
